// File: rtl/video_coord_tracker.sv
// AXI4-Stream video register slice that tags every forwarded beat with its pixel column/row
// and flags line-length and frame-height violations with sticky error bits.
module video_coord_tracker #(
  parameter int COLOR_WIDTH = 8,
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int COORD_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [3*COLOR_WIDTH-1:0] video_in_tdata,
  input  logic                     video_in_tlast,
  input  logic                     video_in_tuser,
  input  logic                     video_in_tvalid,
  output logic                     video_in_tready,
  output logic [3*COLOR_WIDTH-1:0] video_out_tdata,
  output logic                     video_out_tlast,
  output logic                     video_out_tuser,
  output logic                     video_out_tvalid,
  input  logic                     video_out_tready,
  output logic [COORD_WIDTH-1:0]   video_out_X,
  output logic [COORD_WIDTH-1:0]   video_out_Y,
  output logic [15:0]              frame_count,
  output logic                     err_eol_early,
  output logic                     err_eol_late,
  output logic                     err_sof_early,
  input  logic                     err_clear
);

  localparam int DW = 3 * COLOR_WIDTH;
  localparam logic [COORD_WIDTH-1:0] C_MAX  = '1;
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(H_ACTIVE - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(V_ACTIVE - 1);

  typedef struct packed {
    logic [DW-1:0]          data;
    logic                   last;
    logic                   user;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
  } beat_t;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t                 state_reg;
  beat_t                  main_reg, skid_reg, in_beat;
  logic                   main_valid_reg, skid_valid_reg, ready_reg;
  logic [COORD_WIDTH-1:0] prev_x_reg, prev_y_reg, x_new, y_new;
  logic                   prev_last_reg;
  logic [15:0]            frame_count_reg;
  logic                   early_reg, late_reg, sof_reg;
  logic                   accept, forward, early_set, late_set, sof_set;

  assign accept  = video_in_tvalid & ready_reg;
  // Before the first SOF everything is swallowed so the filter never sees a partial frame.
  assign forward = accept & ((state_reg == ACTIVE) | video_in_tuser);

  always_comb begin
    x_new = '0;
    y_new = '0;
    if (state_reg == ACTIVE && !video_in_tuser) begin
      if (prev_last_reg) begin
        y_new = (prev_y_reg == C_MAX) ? C_MAX : prev_y_reg + COORD_WIDTH'(1);
      end else begin
        x_new = (prev_x_reg == C_MAX) ? C_MAX : prev_x_reg + COORD_WIDTH'(1);
        y_new = prev_y_reg;
      end
    end
  end

  assign in_beat   = {video_in_tdata, video_in_tlast, video_in_tuser, x_new, y_new};
  assign early_set = forward & video_in_tlast & (x_new < X_LAST);
  assign late_set  = forward & !video_in_tlast & (x_new == X_LAST);
  assign sof_set   = forward & video_in_tuser & (state_reg == ACTIVE) &
                     !(prev_last_reg & (prev_y_reg == Y_LAST));

  // Slice: a beat only lands in the skid when the main entry is stalled downstream.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else if (main_valid_reg && !video_out_tready) begin
      if (forward) begin
        skid_reg       <= in_beat;
        skid_valid_reg <= 1'b1;
      end
      ready_reg <= !(skid_valid_reg | forward);
    end else if (skid_valid_reg) begin
      main_reg       <= skid_reg;
      main_valid_reg <= 1'b1;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      if (forward) main_reg <= in_beat;
      main_valid_reg <= forward;
      ready_reg      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg       <= WAIT_SOF;
      prev_x_reg      <= '0;
      prev_y_reg      <= '0;
      prev_last_reg   <= 1'b0;
      frame_count_reg <= '0;
      early_reg       <= 1'b0;
      late_reg        <= 1'b0;
      sof_reg         <= 1'b0;
    end else begin
      if (forward) begin
        state_reg     <= ACTIVE;
        prev_x_reg    <= x_new;
        prev_y_reg    <= y_new;
        prev_last_reg <= video_in_tlast;
        if (video_in_tuser) frame_count_reg <= frame_count_reg + 16'd1;
      end
      // A new error in the same cycle as a clear must survive.
      early_reg <= (early_reg & !err_clear) | early_set;
      late_reg  <= (late_reg & !err_clear) | late_set;
      sof_reg   <= (sof_reg & !err_clear) | sof_set;
    end
  end

  assign video_in_tready  = ready_reg;
  assign video_out_tvalid = main_valid_reg;
  assign video_out_tdata  = main_reg.data;
  assign video_out_tlast  = main_reg.last;
  assign video_out_tuser  = main_reg.user;
  assign video_out_X      = main_reg.x;
  assign video_out_Y      = main_reg.y;
  assign frame_count      = frame_count_reg;
  assign err_eol_early    = early_reg;
  assign err_eol_late     = late_reg;
  assign err_sof_early    = sof_reg;

endmodule

// File: tb/tb_video_coord_tracker.sv
// Bench for video_coord_tracker on a 4x3 frame geometry: scoreboard of forwarded beats plus
// a table of beats with the coordinates and flag/frame_count state expected after each one.
module tb_video_coord_tracker;

  localparam int CWD = 8;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            aresetn = 1'b1;
  logic [23:0]     in_tdata = '0;
  logic            in_tlast = 1'b0, in_tuser = 1'b0, in_tvalid = 1'b0;
  logic            in_tready;
  logic [23:0]     out_tdata;
  logic            out_tlast, out_tuser, out_tvalid;
  logic            out_tready = 1'b1;
  logic [CW-1:0]   out_x, out_y;
  logic [15:0]     frame_count;
  logic            err_eol_early, err_eol_late, err_sof_early;
  logic            err_clear = 1'b0;

  video_coord_tracker #(
    .COLOR_WIDTH(CWD), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_WIDTH(CW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .video_in_tdata(in_tdata), .video_in_tlast(in_tlast), .video_in_tuser(in_tuser),
    .video_in_tvalid(in_tvalid), .video_in_tready(in_tready),
    .video_out_tdata(out_tdata), .video_out_tlast(out_tlast), .video_out_tuser(out_tuser),
    .video_out_tvalid(out_tvalid), .video_out_tready(out_tready),
    .video_out_X(out_x), .video_out_Y(out_y), .frame_count(frame_count),
    .err_eol_early(err_eol_early), .err_eol_late(err_eol_late), .err_sof_early(err_sof_early),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0]   d;
    logic          l;
    logic          u;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } exp_t;

  typedef struct {
    logic          u, l, f;
    logic [CW-1:0] x, y;
    logic          clr;
    int            fc;
    logic [2:0]    e;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [23:0] dc = 24'h100;
  bit          rnd_ready = 1'b0;
  exp_t        mon_e;
  bit          hold_v = 1'b0;
  logic [23:0] hold_d;
  logic [9:0]  hold_m;
  logic        r0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic u, l, f, input int x, y, input logic clr,
                              input int fc, input logic [2:0] e);
    vec_t v;
    v.u = u; v.l = l; v.f = f; v.x = CW'(x); v.y = CW'(y); v.clr = clr; v.fc = fc; v.e = e;
    tbl.push_back(v);
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic u, l, f, input logic [CW-1:0] x, y, input logic clr,
                      input bit rnd);
    int  n;
    bit  acc;
    exp_t e;
    if (rnd) begin
      while ($urandom_range(1) == 0) begin
        in_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_tdata = dc; in_tuser = u; in_tlast = l; in_tvalid = 1'b1; err_clear = clr;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_tready;
      n++;
      if (!acc) begin @(posedge clk); #1; end
    end
    if (acc) begin
      if (f) begin
        e.d = dc; e.l = l; e.u = u; e.x = x; e.y = y;
        sb.push_back(e);
      end
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout data %0h got no accept required accept", dc);
    end
    @(posedge clk); #1;
    in_tvalid = 1'b0; err_clear = 1'b0;
    dc = dc + 24'd1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("drain_queue", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard pop on every emitted beat, and payload hold while stalled.
  always @(negedge clk) begin
    if (aresetn && out_tvalid && out_tready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat got data %0h required none", out_tdata);
      end else begin
        mon_e = sb.pop_front();
        chk("out_tdata", out_tdata, mon_e.d);
        chk("out_last_user", {out_tlast, out_tuser}, {mon_e.l, mon_e.u});
        chk("out_x", out_x, mon_e.x);
        chk("out_y", out_y, mon_e.y);
      end
    end
    if (hold_v && out_tvalid) begin
      chk("stall_hold_data", out_tdata, hold_d);
      chk("stall_hold_meta", {out_tlast, out_tuser, out_x, out_y}, hold_m);
    end
    hold_v = aresetn && out_tvalid && !out_tready;
    hold_d = out_tdata;
    hold_m = {out_tlast, out_tuser, out_x, out_y};
  end

  // Random downstream ready; a mid-cycle flip of out_tready must not move in_tready.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) begin
      out_tready = 1'($urandom_range(1));
      #1;
      r0 = in_tready;
      out_tready = !out_tready;
      #1;
      chk("in_tready_comb_path", in_tready, r0);
      out_tready = !out_tready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    int c0;
    // WAIT_SOF drops, then a clean frame
    for (int i = 0; i < 5; i++) add(0, i == 2, 0, 0, 0, 0, 0, 3'b000);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) add(x == 0 && y == 0, x == 3, 1, x, y, 0, 1, 3'b000);
    // early / late / clear / set-wins
    add(1, 0, 1, 0, 0, 0, 2, 3'b000);
    add(0, 0, 1, 1, 0, 0, 2, 3'b000);
    add(0, 1, 1, 2, 0, 0, 2, 3'b100);
    add(0, 0, 1, 0, 1, 0, 2, 3'b100);
    add(0, 0, 1, 1, 1, 0, 2, 3'b100);
    add(0, 0, 1, 2, 1, 0, 2, 3'b100);
    add(0, 0, 1, 3, 1, 0, 2, 3'b110);
    add(0, 1, 1, 4, 1, 0, 2, 3'b110);
    add(0, 0, 1, 0, 2, 1, 2, 3'b000);
    add(0, 0, 1, 1, 2, 0, 2, 3'b000);
    add(0, 0, 1, 2, 2, 0, 2, 3'b000);
    add(0, 1, 1, 3, 2, 0, 2, 3'b000);
    add(0, 0, 1, 0, 3, 0, 2, 3'b000);
    add(0, 1, 1, 1, 3, 1, 2, 3'b100);
    // SOF after too many lines, then after only 2 lines, then SOF+EOL on one beat
    add(1, 0, 1, 0, 0, 0, 3, 3'b101);
    add(0, 0, 1, 1, 0, 1, 3, 3'b000);
    add(0, 0, 1, 2, 0, 0, 3, 3'b000);
    add(0, 1, 1, 3, 0, 0, 3, 3'b000);
    for (int x = 0; x < 4; x++) add(0, x == 3, 1, x, 1, 0, 3, 3'b000);
    add(1, 0, 1, 0, 0, 0, 4, 3'b001);
    add(1, 1, 1, 0, 0, 0, 5, 3'b101);
    // long line: X saturates at 15
    for (int n = 0; n < 18; n++)
      add(0, n == 17, 1, (n > 15) ? 15 : n, 1, 0, 5, (n >= 3) ? 3'b111 : 3'b101);

    // reset state
    #1 aresetn = 1'b0;
    #2;
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_in_tready", in_tready, 0);
    chk("rst_out_payload", {out_tdata, out_tlast, out_tuser}, 0);
    chk("rst_out_xy", {out_x, out_y}, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_errs", {err_eol_early, err_eol_late, err_sof_early}, 0);
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // three clean frames back to back
    c0 = cyc;
    for (int f = 0; f < 3; f++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++)
          send(x == 0 && y == 0, x == 3, 1, CW'(x), CW'(y), 0, 0);
    chk("throughput_cycles", cyc - c0, 36);
    drain();
    chk("frame_count_p1", frame_count, 3);
    chk("errs_p1", {err_eol_early, err_eol_late, err_sof_early}, 0);

    // random valid / ready
    rnd_ready = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++)
          send(x == 0 && y == 0, x == 3, 1, CW'(x), CW'(y), 0, 1);
    rnd_ready = 1'b0;
    @(posedge clk); #5;
    out_tready = 1'b1;
    @(posedge clk); #1;
    drain();
    chk("frame_count_p2", frame_count, 5);
    chk("errs_p2", {err_eol_early, err_eol_late, err_sof_early}, 0);

    // fill both slice entries, then reset mid-line
    out_tready = 1'b0;
    send(1, 0, 1, 0, 0, 0, 0);
    send(0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("full_in_tready", in_tready, 0);
    chk("full_out_tvalid", out_tvalid, 1);
    @(posedge clk); #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_out_tvalid", out_tvalid, 0);
    chk("midrst_out_payload", {out_tdata, out_tlast, out_tuser, out_x, out_y}, 0);
    chk("midrst_in_tready", in_tready, 0);
    chk("midrst_frame_count", frame_count, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    out_tready = 1'b1;
    @(posedge clk); #1;

    // table: WAIT_SOF drop, coordinates and flags after every beat
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].u, tbl[i].l, tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].clr, 0);
      @(negedge clk);
      chk($sformatf("row%0d_frame_count", i), frame_count, tbl[i].fc);
      chk($sformatf("row%0d_errs", i), {err_eol_early, err_eol_late, err_sof_early}, tbl[i].e);
      @(posedge clk); #1;
    end
    drain();

    // lone clear pulse
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    @(negedge clk);
    chk("clear_errs", {err_eol_early, err_eol_late, err_sof_early}, 0);
    chk("final_frame_count", frame_count, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
